// File: rtl/t5_pkg.sv
// Shared widths and helpers for the writeback / scoreboard block.
package t5_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NHART    = 4;
  localparam int unsigned HART_W   = 2;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NREG     = 32;
  localparam int unsigned SB_BITS  = NHART * NREG;
  localparam int unsigned SB_IDX_W = HART_W + REG_W;
  localparam int unsigned TAG_W    = HART_W + REG_W;

  // Destination of a queued load result.
  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic [REG_W-1:0]  rd;
  } wb_tag_t;

  // Flat scoreboard index of (hart, register).
  function automatic logic [SB_IDX_W-1:0] sb_idx(input logic [HART_W-1:0] h,
                                                 input logic [REG_W-1:0]  r);
    return {h, r};
  endfunction

endpackage

// File: rtl/t5_wfifo.sv
// Two-entry load-response FIFO; registered head, no bypass path.
module t5_wfifo #(
  parameter int unsigned W = 39
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_ok;
  logic         pop_ok;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign dout_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      if (wr_ptr_q) mem1_d = din_i;
      else          mem0_d = din_i;
      wr_ptr_d = !wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/t5_wbck.sv
// Writeback arbiter: execute results win, queued loads drain when the port
// is idle; per-hart pending-load scoreboard drives the decode stall.
module t5_wbck
  import t5_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              xvld,
  input  logic [1:0]        xhart,
  input  logic [4:0]        xrda,
  input  logic [XLEN-1:0]   xdat,
  input  logic              lvld,
  output logic              lrdy,
  input  logic [1:0]        lhart,
  input  logic [4:0]        lrda,
  input  logic [XLEN-1:0]   ldat,
  input  logic              ivld,
  input  logic [1:0]        ihart,
  input  logic [4:0]        irda,
  input  logic [1:0]        fhart,
  input  logic [4:0]        rs1a,
  input  logic [4:0]        rs2a,
  output logic              stall,
  output logic              mwre,
  output logic [1:0]        mhart,
  output logic [4:0]        rd0a,
  output logic [XLEN-1:0]   rd0d
);

  localparam int unsigned EW = TAG_W + XLEN;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;
  wb_tag_t           head_tag;
  logic [XLEN-1:0]   head_dat;

  logic              mwre_q, mwre_d;
  logic [1:0]        mhart_q, mhart_d;
  logic [4:0]        rd0a_q, rd0a_d;
  logic [XLEN-1:0]   rd0d_q, rd0d_d;
  logic [SB_BITS-1:0] pend_q, pend_d;

  assign lrdy      = !fifo_full;
  assign fifo_push = lvld && !fifo_full;
  assign fifo_pop  = !xvld && !fifo_empty;
  assign fifo_din  = {lhart, lrda, ldat};
  assign head_tag  = wb_tag_t'(fifo_dout[EW-1 -: TAG_W]);
  assign head_dat  = fifo_dout[XLEN-1:0];

  t5_wfifo #(
    .W (EW)
  ) u_fifo (
    .clk_i   (sclk),
    .rst_ni  (srst_n),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Write-port selection; register 0 is consumed silently, payload holds.
  always_comb begin
    mwre_d  = 1'b0;
    mhart_d = mhart_q;
    rd0a_d  = rd0a_q;
    rd0d_d  = rd0d_q;
    if (xvld) begin
      if (xrda != 5'd0) begin
        mwre_d  = 1'b1;
        mhart_d = xhart;
        rd0a_d  = xrda;
        rd0d_d  = xdat;
      end
    end else if (fifo_pop) begin
      if (head_tag.rd != 5'd0) begin
        mwre_d  = 1'b1;
        mhart_d = head_tag.hart;
        rd0a_d  = head_tag.rd;
        rd0d_d  = head_dat;
      end
    end
  end

  // Scoreboard update: clear on load writeback, then set on issue so set wins.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop && (head_tag.rd != 5'd0)) begin
      pend_d[sb_idx(head_tag.hart, head_tag.rd)] = 1'b0;
    end
    if (ivld && (irda != 5'd0)) begin
      pend_d[sb_idx(ihart, irda)] = 1'b1;
    end
  end

  // Write port and scoreboard registers.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      mwre_q  <= 1'b0;
      mhart_q <= 2'd0;
      rd0a_q  <= 5'd0;
      rd0d_q  <= '0;
      pend_q  <= '0;
    end else begin
      mwre_q  <= mwre_d;
      mhart_q <= mhart_d;
      rd0a_q  <= rd0a_d;
      rd0d_q  <= rd0d_d;
      pend_q  <= pend_d;
    end
  end

  assign mwre  = mwre_q;
  assign mhart = mhart_q;
  assign rd0a  = rd0a_q;
  assign rd0d  = rd0d_q;

  // Decode operand hazard check; register 0 never stalls.
  assign stall = ((rs1a != 5'd0) && pend_q[sb_idx(fhart, rs1a)]) ||
                 ((rs2a != 5'd0) && pend_q[sb_idx(fhart, rs2a)]);

endmodule

// File: doc/t5_wbck.md
T5_WBCK -- requirements
Module: t5_wbck

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 sclk  input  1  system clock; all state changes on the rising edge.
REQ-003 srst_n  input  1  asynchronous, active-low reset.
REQ-004 xvld  input  1  execute result valid; there is no backpressure on this port.
REQ-005 xhart/xrda/xdat  input  2/5/XLEN  execute result hart, destination register, data.
REQ-006 lvld  input  1  load response valid.
REQ-007 lrdy  output  1  load response ready.
REQ-008 lhart/lrda/ldat  input  2/5/XLEN  load response hart, destination register, data.
REQ-009 ivld/ihart/irda  input  1/2/5  load issue event, which marks a register as pending.
REQ-010 fhart/rs1a/rs2a  input  2/5/5  decode-stage operand query.
REQ-011 stall  output  1  the queried rs1a or rs2a is pending a load.
REQ-012 mwre/mhart/rd0a/rd0d  output  1/2/5/XLEN  register-file write port.

Function
REQ-013 Write port outputs SHALL be registered: an accepted result appears on mwre/mhart/rd0a/rd0d exactly 1 cycle after acceptance.
REQ-014 Execute results SHALL have absolute priority: xvld=1 in cycle N gives a write in cycle N+1.
REQ-015 A load response SHALL be accepted into a 2-entry FIFO when lvld&&lrdy; lrdy = !full.
- The source holds lvld and its payload until lrdy.
- Accept and pop in the same cycle are legal when the FIFO is full.
REQ-016 The FIFO head SHALL pop to the write port in any cycle with xvld=0; it is never popped when xvld=1.
REQ-017 FIFO bypass is not allowed: a load accepted in cycle N is written no earlier than cycle N+2.
REQ-018 Writes with destination 0 (xrda=0 or lrda=0) SHALL be consumed but produce mwre=0.
REQ-019 When mwre=0, rd0d/rd0a/mhart SHALL hold their previous values.
REQ-020 Scoreboard: one pending bit per hart per register, 4x32 bits. Bit [h][0] is never set.
REQ-021 ivld SHALL set pending[ihart][irda] on the next edge.
REQ-022 A load result popped to the write port SHALL clear pending[hart][rd] on the same edge that drives mwre.
REQ-023 A simultaneous set and clear of the same bit SHALL leave it set.
REQ-024 Execute-port writes SHALL NOT modify the scoreboard.
REQ-025 stall SHALL be combinational: pending[fhart][rs1a] | pending[fhart][rs2a].
REQ-026 stall SHALL be 0 for register 0.
REQ-027 FIFO order SHALL be strictly first-in-first-out across all harts.

Reset
REQ-028 While srst_n=0, the block SHALL hold:
- mwre=0, mhart=0, rd0a=0, rd0d=0;
- FIFO empty and lrdy=1;
- all pending bits 0, so stall=0.
REQ-029 Reset SHALL take effect asynchronously on assertion. Deassertion SHALL be sampled on sclk.
REQ-030 Reset during an operation SHALL discard FIFO contents and scoreboard state, with no write issued.

Structure
REQ-031 XLEN default, hart count (4) and register-index width (5) SHALL live in shared package t5_pkg.
REQ-032 The load FIFO SHALL be a sub-module t5_wfifo, parameterised on entry width, depth 2.
REQ-033 Scoreboard and arbitration logic SHALL remain in t5_wbck.

Verification
REQ-034 Execute write: xvld=1, xhart=2, xrda=5, xdat=0xDEADBEEF.
- Response: next cycle mwre=1, mhart=2, rd0a=5, rd0d=0xDEADBEEF.
REQ-035 Pending clears on load return: ivld with hart1/r7, then lvld with hart1/r7/0x1234 while xvld=0.
- Response: stall=1 for fhart=1, rs1a=7 until the write cycle.
- Write 2 cycles after accept, then stall=0.
REQ-036 Back-pressure: xvld=1 for 4 cycles while 3 loads arrive.
- Response: lrdy drops after 2 accepts.
- Loads drain in order once xvld=0; none lost or duplicated.
REQ-037 Register 0: xrda=0, or load lrda=0.
- Response: mwre=0 and no scoreboard change.
- stall=0 with rs1a=rs2a=0.
REQ-038 Same-edge set and clear: ivld for hart0/r3 on the same edge as a load write to hart0/r3.
- Response: pending[0][3] remains 1.
REQ-039 Reset mid-stream: srst_n=0 with the FIFO holding 2 entries and pending bits set.
- Response: mwre=0 immediately, lrdy=1, stall=0.
- No write after release.
